// File: rtl/fb_seq_pkg.sv
// rtl/fb_seq_pkg.sv - shared types and constants for the framebuffer address sequencer
// Contents:
//   state_t                 sequencer state (IDLE / RUN / DONE)
//   MODE_WRAP/MODE_ONESHOT  frame mode encodings for the mode input
//   DIR_UP/DIR_DOWN         scan direction encodings for the dir input
package fb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/fb_coord_counter.sv
// rtl/fb_coord_counter.sv - col/row/linear-address counter with carry, load and origin preset
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   load, load_col/row   load clamped coordinates (highest priority after reset)
//   preset               jump to the frame origin for the given dir
//   step                 advance one pixel in raster order in the given dir
//   dir                  0 = ascending, 1 = descending
//   col, row, addr       registered position; addr = row*COLS + col
module fb_coord_counter
  import fb_seq_pkg::*;
#(
  parameter int COLS   = 100,
  parameter int ROWS   = 100,
  parameter int ADDR_W = 16,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [COL_W-1:0]  load_col,
  input  logic [ROW_W-1:0]  load_row,
  input  logic              preset,
  input  logic              step,
  input  logic              dir,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(COLS * ROWS - 1);
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [COL_W-1:0]  C_ONE   = COL_W'(1);
  localparam logic [ROW_W-1:0]  R_ONE   = ROW_W'(1);

  logic [COL_W-1:0] lc;
  logic [ROW_W-1:0] lr;

  // Out-of-range load coordinates saturate to the last column/row so addr stays <= LAST.
  assign lc = (load_col > COL_MAX) ? COL_MAX : load_col;
  assign lr = (load_row > ROW_MAX) ? ROW_MAX : load_row;

  always_ff @(posedge clk) begin
    if (!rst) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (load) begin
      col  <= lc;
      row  <= lr;
      // Only place the multiply is needed; stepping keeps addr in lockstep incrementally.
      addr <= ADDR_W'(lr) * ADDR_W'(COLS) + ADDR_W'(lc);
    end else if (preset) begin
      if (dir == DIR_DOWN) begin
        col  <= COL_MAX;
        row  <= ROW_MAX;
        addr <= LAST;
      end else begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end
    end else if (step) begin
      if (dir == DIR_DOWN) begin
        addr <= addr - A_ONE;
        if (col == '0) begin
          col <= COL_MAX;
          row <= row - R_ONE;
        end else begin
          col <= col - C_ONE;
        end
      end else begin
        addr <= addr + A_ONE;
        if (col == COL_MAX) begin
          col <= '0;
          row <= row + R_ONE;
        end else begin
          col <= col + C_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/fb_addr_sequencer.sv
// rtl/fb_addr_sequencer.sv - raster-order framebuffer address sequencer with ready/valid output
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   en                     global advance enable
//   mode                   0 = continuous wrap, 1 = one-shot
//   dir                    0 = ascending, 1 = descending
//   start                  begin/restart a frame from the origin
//   load, load_col/row     load coordinates (any state, no pulses)
//   addr_ready             consumer accepts the current address
//   addr, col, row         current position
//   addr_valid, busy       high while in RUN
//   frame_start            pulse: first address of a frame is presented
//   frame_done             pulse: terminal address was accepted
module fb_addr_sequencer
  import fb_seq_pkg::*;
#(
  parameter int COLS   = 100,
  parameter int ROWS   = 100,
  parameter int ADDR_W = 16,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              dir,
  input  logic              start,
  input  logic              load,
  input  logic [COL_W-1:0]  load_col,
  input  logic [ROW_W-1:0]  load_row,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic              addr_valid,
  output logic              busy,
  output logic              frame_start,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * ROWS - 1);

  state_t state, next_state;
  logic   xfer, terminal, preset, step, fs_d, fd_d;

  assign addr_valid = (state == RUN);
  assign busy       = (state == RUN);
  assign xfer       = addr_valid && addr_ready && en;
  assign terminal   = (dir == DIR_UP) ? (addr == LAST) : (addr == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= next_state;
      frame_start <= fs_d;
      frame_done  <= fd_d;
    end
  end

  // Load only moves the position; it suppresses any advance but never blocks a start.
  always_comb begin
    next_state = state;
    fs_d       = 1'b0;
    fd_d       = 1'b0;
    preset     = 1'b0;
    step       = 1'b0;
    if (start) begin
      next_state = RUN;
      fs_d       = 1'b1;
      preset     = 1'b1;
    end else if (xfer && !load) begin
      if (terminal) begin
        fd_d = 1'b1;
        if (mode == MODE_ONESHOT) begin
          next_state = DONE;
        end else begin
          preset = 1'b1;
          fs_d   = 1'b1;
        end
      end else begin
        step = 1'b1;
      end
    end
  end

  fb_coord_counter #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_col (load_col),
    .load_row (load_row),
    .preset   (preset),
    .step     (step),
    .dir      (dir),
    .col      (col),
    .row      (row),
    .addr     (addr)
  );

endmodule

// File: tb/tb_fb_addr_sequencer.sv
// tb/tb_fb_addr_sequencer.sv - scoreboard bench for fb_addr_sequencer against a linear-index model
module tb_fb_addr_sequencer;

  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = COLS * ROWS;

  logic clk, rst, en, mode, dir, start, load, addr_ready;
  logic [1:0] load_col, load_row;
  logic [ADDR_W-1:0] addr;
  logic [1:0] col, row;
  logic addr_valid, busy, frame_start, frame_done;

  fb_addr_sequencer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .dir        (dir),
    .start      (start),
    .load       (load),
    .load_col   (load_col),
    .load_row   (load_row),
    .addr_ready (addr_ready),
    .addr       (addr),
    .col        (col),
    .row        (row),
    .addr_valid (addr_valid),
    .busy       (busy),
    .frame_start(frame_start),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int addr;
    int col;
    int row;
    bit valid;
    bit busy;
    bit fs;
    bit fd;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference: position is a single raster index; state 0=idle 1=run 2=done.
  int m_state = 0;
  int m_idx = 0;

  // Called right after a negedge with inputs already set; predicts the state after the next posedge.
  task automatic tick();
    exp_t e;
    bit   xfer;
    int   origin, lc, lr;
    e.fs = 1'b0;
    e.fd = 1'b0;
    if (!rst) begin
      m_state = 0;
      m_idx   = 0;
    end else begin
      xfer   = (m_state == 1) && addr_ready && en;
      origin = dir ? DEPTH - 1 : 0;
      if (load) begin
        lc    = (int'(load_col) > COLS - 1) ? COLS - 1 : int'(load_col);
        lr    = (int'(load_row) > ROWS - 1) ? ROWS - 1 : int'(load_row);
        m_idx = lr * COLS + lc;
      end
      if (start) begin
        m_state = 1;
        e.fs    = 1'b1;
        if (!load) m_idx = origin;
      end else if (xfer && !load) begin
        if (m_idx == (dir ? 0 : DEPTH - 1)) begin
          e.fd = 1'b1;
          if (mode) m_state = 2;
          else begin
            m_idx = origin;
            e.fs  = 1'b1;
          end
        end else begin
          m_idx = m_idx + (dir ? -1 : 1);
        end
      end
    end
    e.addr  = m_idx;
    e.col   = m_idx % COLS;
    e.row   = m_idx / COLS;
    e.valid = (m_state == 1);
    e.busy  = (m_state == 1);
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if ($isunknown({addr, col, row, addr_valid, busy, frame_start, frame_done}) ||
            int'(addr) != e.addr || int'(col) != e.col || int'(row) != e.row ||
            addr_valid != e.valid || busy != e.busy ||
            frame_start != e.fs || frame_done != e.fd) begin
          miscompares++;
          $display("FAIL snapshot t=%0t got addr=%0d col=%0d row=%0d v=%b b=%b fs=%b fd=%b exp addr=%0d col=%0d row=%0d v=%b b=%b fs=%b fd=%b",
                   $time, addr, col, row, addr_valid, busy, frame_start, frame_done,
                   e.addr, e.col, e.row, e.valid, e.busy, e.fs, e.fd);
        end
        vectors++;
        if (int'(addr) > DEPTH - 1) begin
          miscompares++;
          $display("FAIL addr_range t=%0t got addr=%0d exp <= %0d", $time, addr, DEPTH - 1);
        end
      end
    end
  end

  initial begin
    logic rp [4];
    rp = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b0; en = 1'b1; mode = 1'b0; dir = 1'b0; start = 1'b0; load = 1'b0;
    load_col = '0; load_row = '0; addr_ready = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // continuous ascending frame, wraps once
    start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();

    // one-shot descending to DONE, then restart
    mode = 1'b1; dir = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();

    // backpressure and pause
    mode = 1'b0; dir = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    foreach (rp[i]) begin
      addr_ready = rp[i];
      tick();
    end
    addr_ready = 1'b1;
    en = 1'b0; repeat (2) tick();
    en = 1'b1; repeat (2) tick();

    // clamped load to last pixel, then terminal wrap
    load = 1'b1; load_col = 2'd3; load_row = 2'd3; tick(); load = 1'b0;
    repeat (2) tick();

    // reset mid-frame at addr 6, then restart
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    rst = 1'b0; tick(); rst = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();

    // load and start together from IDLE
    rst = 1'b0; tick(); rst = 1'b1;
    load = 1'b1; start = 1'b1; load_col = 2'd1; load_row = 2'd1; tick();
    load = 1'b0; start = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 199) != 0);
      en         = ($urandom_range(0, 9) != 0);
      start      = ($urandom_range(0, 39) == 0);
      load       = ($urandom_range(0, 29) == 0);
      load_col   = 2'($urandom);
      load_row   = 2'($urandom);
      addr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      tick();
    end

    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
